// File: rtl/cv32e40p_x_arb_pkg.sv
// Shared types for the X-interface issue arbiter: FSM state and the muxed issue payload.
package cv32e40p_x_arb_pkg;

  localparam int unsigned ARB_NUM_REQ_DEF  = 2;
  localparam int unsigned ARB_ID_WIDTH_DEF = 4;
  localparam int unsigned ARB_LID_W        = ARB_ID_WIDTH_DEF - $clog2(ARB_NUM_REQ_DEF);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  // The lid field follows the package default geometry; the top casts to its own LID_W.
  typedef struct packed {
    logic [31:0]      instr;
    logic [2:0][31:0] rs;
    logic [2:0]       rs_valid;
    logic [ARB_LID_W-1:0] lid;
  } x_issue_req_t;

endpackage

// File: rtl/cv32e40p_x_rr_arbiter.sv
// Combinational round-robin picker: first eligible requester at or after the pointer.
module cv32e40p_x_rr_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  localparam int unsigned IDX_W  = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] eligible_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] grant_oh_o,
  output logic [IDX_W-1:0]   grant_idx_o,
  output logic               grant_valid_o
);

  logic [IDX_W-1:0] cand;

  // Scanning from the farthest offset down leaves the closest eligible requester as the winner.
  always_comb begin
    cand          = '0;
    grant_oh_o    = '0;
    grant_idx_o   = '0;
    grant_valid_o = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = ptr_i + IDX_W'(k);
      if (eligible_i[cand]) begin
        grant_idx_o   = cand;
        grant_valid_o = 1'b1;
      end
    end
    if (grant_valid_o) grant_oh_o = NUM_REQ'(1) << grant_idx_o;
  end

endmodule

// File: rtl/cv32e40p_x_issue_arb.sv
// Shares one coprocessor X-interface between NUM_REQ cores: round-robin issue, result routing by id MSBs.
// Optional CV32E40P_X_ARB_PERF_EN adds saturating per-requester stall counters on perf_stall_o.
module cv32e40p_x_issue_arb
  import cv32e40p_x_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 2,
  parameter int unsigned ID_WIDTH  = 4,
  parameter int unsigned MAX_OUTST = 4,
  localparam int unsigned IDX_W    = $clog2(NUM_REQ),
  localparam int unsigned LID_W    = ID_WIDTH - IDX_W,
  localparam int unsigned CNT_W    = $clog2(MAX_OUTST + 1)
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NUM_REQ-1:0]             req_valid_i,
  output logic [NUM_REQ-1:0]             req_ready_o,
  input  logic [NUM_REQ-1:0][31:0]       req_instr_i,
  input  logic [NUM_REQ-1:0][2:0][31:0]  req_rs_i,
  input  logic [NUM_REQ-1:0][2:0]        req_rs_valid_i,
  input  logic [NUM_REQ-1:0][LID_W-1:0]  req_id_i,
  output logic                           req_resp_accept_o,
  output logic                           req_resp_wb_o,
  output logic                           x_issue_valid_o,
  input  logic                           x_issue_ready_i,
  output logic [31:0]                    x_issue_instr_o,
  output logic [2:0][31:0]               x_issue_rs_o,
  output logic [2:0]                     x_issue_rs_valid_o,
  output logic [ID_WIDTH-1:0]            x_issue_id_o,
  input  logic                           x_issue_resp_accept_i,
  input  logic                           x_issue_resp_writeback_i,
  input  logic                           x_result_valid_i,
  output logic                           x_result_ready_o,
  input  logic [ID_WIDTH-1:0]            x_result_id_i,
  input  logic [31:0]                    x_result_data_i,
  input  logic [4:0]                     x_result_rd_i,
  input  logic                           x_result_we_i,
  output logic [NUM_REQ-1:0]             res_valid_o,
  input  logic [NUM_REQ-1:0]             res_ready_i,
  output logic [LID_W-1:0]               res_id_o,
  output logic [31:0]                    res_data_o,
  output logic [4:0]                     res_rd_o,
  output logic                           res_we_o,
  output logic                           err_o
`ifdef CV32E40P_X_ARB_PERF_EN
  ,
  output logic [NUM_REQ-1:0][15:0]       perf_stall_o
`endif
);

  arb_state_e                     state_q;
  logic [IDX_W-1:0]               rrPtr_q;
  logic [IDX_W-1:0]               grant_q;
  logic [NUM_REQ-1:0][CNT_W-1:0]  outst_q;
  logic [NUM_REQ-1:0][CNT_W-1:0]  outst_d;
  logic                           err_q;
  logic                           err_d;

  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] outstNz;
  logic [NUM_REQ-1:0] arbOh;
  logic [IDX_W-1:0]   arbIdx;
  logic               arbValid;
  logic [NUM_REQ-1:0] grantOh;
  logic [IDX_W-1:0]   grantIdx;
  logic               issueHs;
  logic [IDX_W-1:0]   resIdx;
  logic [NUM_REQ-1:0] resOh;
  logic               resHs;
  logic [NUM_REQ-1:0] outstInc;
  logic [NUM_REQ-1:0] outstDec;
  x_issue_req_t       issueSel;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      outstNz[i]  = (outst_q[i] != '0);
      eligible[i] = req_valid_i[i] & (outst_q[i] != CNT_W'(MAX_OUTST));
    end
  end

  cv32e40p_x_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .eligible_i    (eligible),
    .ptr_i         (rrPtr_q),
    .grant_oh_o    (arbOh),
    .grant_idx_o   (arbIdx),
    .grant_valid_o (arbValid)
  );

  // While locked the grant is frozen so the coprocessor sees a stable payload until it accepts.
  always_comb begin
    if (state_q == LOCKED) begin
      grantIdx        = grant_q;
      grantOh         = NUM_REQ'(1) << grant_q;
      x_issue_valid_o = ~rst_i & req_valid_i[grant_q];
    end else begin
      grantIdx        = arbIdx;
      grantOh         = arbOh;
      x_issue_valid_o = ~rst_i & arbValid;
    end
  end

  assign issueHs           = x_issue_valid_o & x_issue_ready_i;
  assign req_ready_o       = grantOh & {NUM_REQ{issueHs}};
  assign req_resp_accept_o = issueHs & x_issue_resp_accept_i;
  assign req_resp_wb_o     = issueHs & x_issue_resp_writeback_i;

  always_comb begin
    issueSel          = '0;
    issueSel.instr    = req_instr_i[grantIdx];
    issueSel.rs       = req_rs_i[grantIdx];
    issueSel.rs_valid = req_rs_valid_i[grantIdx];
    issueSel.lid      = ARB_LID_W'(req_id_i[grantIdx]);
  end

  assign x_issue_instr_o    = issueSel.instr;
  assign x_issue_rs_o       = issueSel.rs;
  assign x_issue_rs_valid_o = issueSel.rs_valid;
  assign x_issue_id_o       = {grantIdx, LID_W'(issueSel.lid)};

  assign resIdx           = x_result_id_i[ID_WIDTH-1 -: IDX_W];
  assign resOh            = NUM_REQ'(1) << resIdx;
  assign x_result_ready_o = ~rst_i & res_ready_i[resIdx];
  assign res_valid_o      = rst_i ? '0 : (resOh & {NUM_REQ{x_result_valid_i}});
  assign resHs            = x_result_valid_i & x_result_ready_o;
  assign res_id_o         = x_result_id_i[LID_W-1:0];
  assign res_data_o       = x_result_data_i;
  assign res_rd_o         = x_result_rd_i;
  assign res_we_o         = x_result_we_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      rrPtr_q <= '0;
      grant_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (arbValid) begin
            grant_q <= arbIdx;
            if (x_issue_ready_i) rrPtr_q <= arbIdx + IDX_W'(1);
            else                 state_q <= LOCKED;
          end
        end
        LOCKED: begin
          if (issueHs) begin
            state_q <= IDLE;
            rrPtr_q <= grant_q + IDX_W'(1);
          end else if (!req_valid_i[grant_q]) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Only writeback instructions occupy a slot; a stray result never underflows, it flags err.
  assign outstInc = grantOh & {NUM_REQ{issueHs & x_issue_resp_accept_i & x_issue_resp_writeback_i}};
  assign outstDec = resOh & outstNz & {NUM_REQ{resHs}};

  always_comb begin
    outst_d = outst_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (outstInc[i] && !outstDec[i])      outst_d[i] = outst_q[i] + CNT_W'(1);
      else if (outstDec[i] && !outstInc[i]) outst_d[i] = outst_q[i] - CNT_W'(1);
    end
    err_d = err_q | (resHs & ~outstNz[resIdx]);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      outst_q <= '0;
      err_q   <= 1'b0;
    end else begin
      outst_q <= outst_d;
      err_q   <= err_d;
    end
  end

  assign err_o = err_q & ~rst_i;

`ifdef CV32E40P_X_ARB_PERF_EN
  logic [NUM_REQ-1:0][15:0] perfStall_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perfStall_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_valid_i[i] && !req_ready_o[i] && (perfStall_q[i] != 16'hFFFF))
          perfStall_q[i] <= perfStall_q[i] + 16'd1;
      end
    end
  end

  assign perf_stall_o = perfStall_q;
`endif

endmodule

// File: tb/tb_cv32e40p_x_issue_arb.sv
// Directed vector bench for cv32e40p_x_issue_arb: a table of cycles plus hand-built corner sequences.
module tb_cv32e40p_x_issue_arb;

  localparam int unsigned NUM_REQ  = 2;
  localparam int unsigned ID_WIDTH = 4;
  localparam int unsigned LID_W    = 3;

  logic                          clk;
  logic                          rst;
  logic [NUM_REQ-1:0]            reqValid;
  logic [NUM_REQ-1:0]            reqReady;
  logic [NUM_REQ-1:0][31:0]      reqInstr;
  logic [NUM_REQ-1:0][2:0][31:0] reqRs;
  logic [NUM_REQ-1:0][2:0]       reqRsValid;
  logic [NUM_REQ-1:0][LID_W-1:0] reqId;
  logic                          respAccept;
  logic                          respWb;
  logic                          issueValid;
  logic                          issueReady;
  logic [31:0]                   issueInstr;
  logic [2:0][31:0]              issueRs;
  logic [2:0]                    issueRsValid;
  logic [ID_WIDTH-1:0]           issueId;
  logic                          xAccept;
  logic                          xWb;
  logic                          resultValid;
  logic                          resultReady;
  logic [ID_WIDTH-1:0]           resultId;
  logic [31:0]                   resultData;
  logic [4:0]                    resultRd;
  logic                          resultWe;
  logic [NUM_REQ-1:0]            resValid;
  logic [NUM_REQ-1:0]            resReady;
  logic [LID_W-1:0]              resId;
  logic [31:0]                   resData;
  logic [4:0]                    resRd;
  logic                          resWe;
  logic                          err;
`ifdef CV32E40P_X_ARB_PERF_EN
  logic [NUM_REQ-1:0][15:0]      perfStall;
`endif

  int checkCount = 0;
  int passCount  = 0;

  cv32e40p_x_issue_arb #(
    .NUM_REQ   (NUM_REQ),
    .ID_WIDTH  (ID_WIDTH),
    .MAX_OUTST (4)
  ) dut (
    .clk_i                    (clk),
    .rst_i                    (rst),
    .req_valid_i              (reqValid),
    .req_ready_o              (reqReady),
    .req_instr_i              (reqInstr),
    .req_rs_i                 (reqRs),
    .req_rs_valid_i           (reqRsValid),
    .req_id_i                 (reqId),
    .req_resp_accept_o        (respAccept),
    .req_resp_wb_o            (respWb),
    .x_issue_valid_o          (issueValid),
    .x_issue_ready_i          (issueReady),
    .x_issue_instr_o          (issueInstr),
    .x_issue_rs_o             (issueRs),
    .x_issue_rs_valid_o       (issueRsValid),
    .x_issue_id_o             (issueId),
    .x_issue_resp_accept_i    (xAccept),
    .x_issue_resp_writeback_i (xWb),
    .x_result_valid_i         (resultValid),
    .x_result_ready_o         (resultReady),
    .x_result_id_i            (resultId),
    .x_result_data_i          (resultData),
    .x_result_rd_i            (resultRd),
    .x_result_we_i            (resultWe),
    .res_valid_o              (resValid),
    .res_ready_i              (resReady),
    .res_id_o                 (resId),
    .res_data_o               (resData),
    .res_rd_o                 (resRd),
    .res_we_o                 (resWe),
    .err_o                    (err)
`ifdef CV32E40P_X_ARB_PERF_EN
    ,
    .perf_stall_o             (perfStall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [1:0] rv;
    logic       ir;
    logic       acc;
    logic       wb;
    logic       xrv;
    logic [3:0] xrid;
    logic [1:0] rr;
    logic       eIv;
    logic [3:0] eId;
    logic [1:0] eRdy;
    logic [1:0] eRvo;
    logic       eXrr;
    logic       eErr;
    logic [2:0] eResId;
  } vec_t;

  function automatic vec_t mkVec(
    input logic rst_, input logic [1:0] rv, input logic ir, input logic acc, input logic wb,
    input logic xrv, input logic [3:0] xrid, input logic [1:0] rr,
    input logic eIv, input logic [3:0] eId, input logic [1:0] eRdy, input logic [1:0] eRvo,
    input logic eXrr, input logic eErr, input logic [2:0] eResId);
    vec_t v;
    v.rst = rst_; v.rv = rv; v.ir = ir; v.acc = acc; v.wb = wb;
    v.xrv = xrv; v.xrid = xrid; v.rr = rr;
    v.eIv = eIv; v.eId = eId; v.eRdy = eRdy; v.eRvo = eRvo;
    v.eXrr = eXrr; v.eErr = eErr; v.eResId = eResId;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected)
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    else
      passCount++;
  endtask

  task automatic applyStimulus(input vec_t v);
    rst         = v.rst;
    reqValid    = v.rv;
    issueReady  = v.ir;
    xAccept     = v.acc;
    xWb         = v.wb;
    resultValid = v.xrv;
    resultId    = v.xrid;
    resReady    = v.rr;
  endtask

  // One cycle: drive after the falling edge, sample 1ns later, state commits on the next rising edge.
  task automatic runVec(input vec_t v, input string tag);
    @(negedge clk);
    applyStimulus(v);
    #1;
    checkOutput({tag, ".issueValid"}, 32'(issueValid),  32'(v.eIv));
    checkOutput({tag, ".issueId"},    32'(issueId),     32'(v.eId));
    checkOutput({tag, ".reqReady"},   32'(reqReady),    32'(v.eRdy));
    checkOutput({tag, ".resValid"},   32'(resValid),    32'(v.eRvo));
    checkOutput({tag, ".xResReady"},  32'(resultReady), 32'(v.eXrr));
    checkOutput({tag, ".err"},        32'(err),         32'(v.eErr));
    checkOutput({tag, ".resId"},      32'(resId),       32'(v.eResId));
  endtask

  vec_t table0[10];

  initial begin
    reqInstr[0]   = 32'h0000_1111;
    reqInstr[1]   = 32'h2222_0000;
    reqRs[0]      = {32'hA0A0_0002, 32'hA0A0_0001, 32'hA0A0_0000};
    reqRs[1]      = {32'hB1B1_0002, 32'hB1B1_0001, 32'hB1B1_0000};
    reqRsValid[0] = 3'b001;
    reqRsValid[1] = 3'b110;
    reqId         = '0;
    resultData    = 32'hDEAD_BEEF;
    resultRd      = 5'd7;
    resultWe      = 1'b1;
    applyStimulus(mkVec(1, 2'b00, 0, 0, 0, 0, 4'h0, 2'b00, 0, 4'h0, 2'b00, 2'b00, 0, 0, 3'd0));
    repeat (2) @(posedge clk);

    // Alternating grants, then result routing and the stray-result error.
    table0[0] = mkVec(1, 2'b11, 1, 1, 1, 1, 4'hA, 2'b11, 0, 4'h0, 2'b00, 2'b00, 0, 0, 3'd2);
    table0[1] = mkVec(0, 2'b11, 1, 1, 1, 0, 4'h0, 2'b00, 1, 4'h0, 2'b01, 2'b00, 0, 0, 3'd0);
    table0[2] = mkVec(0, 2'b11, 1, 1, 1, 0, 4'h0, 2'b00, 1, 4'h8, 2'b10, 2'b00, 0, 0, 3'd0);
    table0[3] = mkVec(0, 2'b11, 1, 1, 1, 0, 4'h0, 2'b00, 1, 4'h0, 2'b01, 2'b00, 0, 0, 3'd0);
    table0[4] = mkVec(0, 2'b11, 1, 1, 1, 0, 4'h0, 2'b00, 1, 4'h8, 2'b10, 2'b00, 0, 0, 3'd0);
    table0[5] = mkVec(0, 2'b00, 1, 0, 0, 1, 4'hA, 2'b10, 0, 4'h0, 2'b00, 2'b10, 1, 0, 3'd2);
    table0[6] = mkVec(0, 2'b00, 1, 0, 0, 1, 4'h9, 2'b01, 0, 4'h0, 2'b00, 2'b10, 0, 0, 3'd1);
    table0[7] = mkVec(0, 2'b00, 1, 0, 0, 1, 4'h9, 2'b10, 0, 4'h0, 2'b00, 2'b10, 1, 0, 3'd1);
    table0[8] = mkVec(0, 2'b00, 1, 0, 0, 1, 4'h9, 2'b11, 0, 4'h0, 2'b00, 2'b10, 1, 0, 3'd1);
    table0[9] = mkVec(0, 2'b00, 1, 0, 0, 0, 4'h0, 2'b00, 0, 4'h0, 2'b00, 2'b00, 0, 1, 3'd0);
    for (int i = 0; i < 10; i++) runVec(table0[i], $sformatf("tbl%0d", i));

    // Grant lock: req1 held with ready low, req0 arrives late and must wait.
    reqId[0] = 3'd3;
    reqId[1] = 3'd5;
    runVec(mkVec(1, 2'b00, 0, 0, 0, 0, 4'h0, 2'b00, 0, 4'h3, 2'b00, 2'b00, 0, 0, 3'd0), "lockRst");
    runVec(mkVec(0, 2'b10, 0, 1, 0, 0, 4'h0, 2'b00, 1, 4'hD, 2'b00, 2'b00, 0, 0, 3'd0), "lockA");
    checkOutput("lockA.respAccept", 32'(respAccept), 32'd0);
    runVec(mkVec(0, 2'b11, 0, 1, 0, 0, 4'h0, 2'b00, 1, 4'hD, 2'b00, 2'b00, 0, 0, 3'd0), "lockB");
    checkOutput("lockB.instr",   issueInstr,         32'h2222_0000);
    checkOutput("lockB.rs2",     issueRs[2],         32'hB1B1_0002);
    checkOutput("lockB.rsValid", 32'(issueRsValid),  32'b110);
    runVec(mkVec(0, 2'b11, 0, 1, 0, 0, 4'h0, 2'b00, 1, 4'hD, 2'b00, 2'b00, 0, 0, 3'd0), "lockC");
    checkOutput("lockC.rs0", issueRs[0], 32'hB1B1_0000);
    runVec(mkVec(0, 2'b11, 1, 1, 0, 0, 4'h0, 2'b00, 1, 4'hD, 2'b10, 2'b00, 0, 0, 3'd0), "lockD");
    checkOutput("lockD.respAccept", 32'(respAccept), 32'd1);
    checkOutput("lockD.respWb",     32'(respWb),     32'd0);
    runVec(mkVec(0, 2'b11, 1, 0, 0, 0, 4'h0, 2'b00, 1, 4'h3, 2'b01, 2'b00, 0, 0, 3'd0), "lockE");
    checkOutput("lockE.instr", issueInstr, 32'h0000_1111);
`ifdef CV32E40P_X_ARB_PERF_EN
    checkOutput("lockE.perfStall1", 32'(perfStall[1]), 32'd3);
`endif
    reqId = '0;

    // Outstanding limit on req0, req1 still served, simultaneous issue+result, stray result.
    runVec(mkVec(1, 2'b00, 0, 0, 0, 0, 4'h0, 2'b00, 0, 4'h0, 2'b00, 2'b00, 0, 0, 3'd0), "limRst");
    for (int i = 0; i < 4; i++)
      runVec(mkVec(0, 2'b01, 1, 1, 1, 0, 4'h0, 2'b00, 1, 4'h0, 2'b01, 2'b00, 0, 0, 3'd0),
             $sformatf("limIssue%0d", i));
    runVec(mkVec(0, 2'b01, 1, 1, 1, 0, 4'h0, 2'b00, 0, 4'h0, 2'b00, 2'b00, 0, 0, 3'd0), "limFull");
    runVec(mkVec(0, 2'b11, 1, 1, 1, 0, 4'h0, 2'b00, 1, 4'h8, 2'b10, 2'b00, 0, 0, 3'd0), "limOther");
    runVec(mkVec(0, 2'b00, 1, 0, 0, 1, 4'h0, 2'b01, 0, 4'h0, 2'b00, 2'b01, 1, 0, 3'd0), "limRes");
    runVec(mkVec(0, 2'b01, 1, 1, 1, 1, 4'h1, 2'b01, 1, 4'h0, 2'b01, 2'b01, 1, 0, 3'd1), "sameCyc");
    runVec(mkVec(0, 2'b01, 1, 1, 1, 0, 4'h0, 2'b00, 1, 4'h0, 2'b01, 2'b00, 0, 0, 3'd0), "lastSlot");
    runVec(mkVec(0, 2'b01, 1, 1, 1, 0, 4'h0, 2'b00, 0, 4'h0, 2'b00, 2'b00, 0, 0, 3'd0), "fullAgain");
    runVec(mkVec(0, 2'b00, 1, 0, 0, 1, 4'h8, 2'b10, 0, 4'h0, 2'b00, 2'b10, 1, 0, 3'd0), "drain1");
    runVec(mkVec(0, 2'b00, 1, 0, 0, 1, 4'h9, 2'b10, 0, 4'h0, 2'b00, 2'b10, 1, 0, 3'd1), "stray");
    runVec(mkVec(0, 2'b00, 1, 0, 0, 0, 4'h0, 2'b00, 0, 4'h0, 2'b00, 2'b00, 0, 1, 3'd0), "errSticky");

    // Reset while locked with three writebacks in flight.
    runVec(mkVec(1, 2'b00, 0, 0, 0, 0, 4'h0, 2'b00, 0, 4'h0, 2'b00, 2'b00, 0, 0, 3'd0), "midRst0");
    for (int i = 0; i < 3; i++)
      runVec(mkVec(0, 2'b01, 1, 1, 1, 0, 4'h0, 2'b00, 1, 4'h0, 2'b01, 2'b00, 0, 0, 3'd0),
             $sformatf("midIssue%0d", i));
    runVec(mkVec(0, 2'b01, 0, 1, 1, 0, 4'h0, 2'b00, 1, 4'h0, 2'b00, 2'b00, 0, 0, 3'd0), "midLock");
    runVec(mkVec(1, 2'b01, 0, 1, 1, 0, 4'h0, 2'b00, 0, 4'h0, 2'b00, 2'b00, 0, 0, 3'd0), "midRst");
    runVec(mkVec(0, 2'b00, 1, 0, 0, 0, 4'h0, 2'b00, 0, 4'h0, 2'b00, 2'b00, 0, 0, 3'd0), "postRst");
    runVec(mkVec(0, 2'b10, 1, 0, 0, 0, 4'h0, 2'b00, 1, 4'h8, 2'b10, 2'b00, 0, 0, 3'd0), "postIdle");
    for (int i = 0; i < 4; i++)
      runVec(mkVec(0, 2'b01, 1, 1, 1, 0, 4'h0, 2'b00, 1, 4'h0, 2'b01, 2'b00, 0, 0, 3'd0),
             $sformatf("postIssue%0d", i));
    runVec(mkVec(0, 2'b01, 1, 1, 1, 0, 4'h0, 2'b00, 0, 4'h0, 2'b00, 2'b00, 0, 0, 3'd0), "postFull");

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
